ones_pattern_tx: RTL and testbench

- Inverse of the team's 7-input ones-counter: takes a 3-bit ones count and builds a 7-bit word containing exactly that many 1s.
- Transmits the word bit-serially, LSB first, over a valid/ready link.
- Sits at the stimulus/transmit end of the ones-count path, so a downstream deserializer plus ones-counter must return the original count.

---
 rtl/ones_pkg.sv | 17 +
 rtl/therm_gen.sv | 44 ++++
 rtl/ones_pattern_tx.sv | 151 +++++++++++++++
 tb/tb_ones_pattern_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_pkg.sv
// Shared definitions for the ones-pattern transmit path: default geometry,
// frame FSM states and fill-mode encodings.
package ones_pkg;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_CW    = 3;

    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/therm_gen.sv
// Thermometer word generator: turns a ones count into a WIDTH-bit word holding
// exactly min(count, WIDTH) ones, packed at the LSB or MSB end.
module therm_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic [CW-1:0]    count,
    input  logic             mode,
    output logic [WIDTH-1:0] word,
    output logic             sat
);

    localparam logic [CW:0]    WIDTH_C = (CW+1)'(WIDTH);
    localparam logic [WIDTH:0] ONE_W   = (WIDTH+1)'(1);

    logic [CW:0]      n_s;
    logic [CW:0]      pad_s;
    logic [WIDTH:0]   mask_s;
    logic [WIDTH-1:0] lsb_word_s;

    // Clamp the count, build the mask one bit wider so n == WIDTH cannot overflow, then place it.
    always_comb begin
        n_s        = {1'b0, count};
        sat        = 1'b0;
        if ({1'b0, count} > WIDTH_C) begin
            n_s = WIDTH_C;
            sat = 1'b1;
        end else begin
            n_s = {1'b0, count};
            sat = 1'b0;
        end
        mask_s     = (ONE_W << n_s) - ONE_W;
        lsb_word_s = mask_s[WIDTH-1:0];
        pad_s      = WIDTH_C - n_s;
        case (mode)
            MODE_LSB: word = lsb_word_s;
            MODE_MSB: word = lsb_word_s << pad_s;
            default:  word = lsb_word_s;
        endcase
    end

endmodule

// File: rtl/ones_pattern_tx.sv
// Ones-pattern transmitter: accepts a ones count, builds the matching thermometer
// word and sends it LSB first over a valid/ready serial link, then pulses done.
module ones_pattern_tx
    import ones_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    input  logic             in_mode,
    output logic [WIDTH-1:0] word_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             done,
    output logic             sat
);

    localparam int                IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0]   IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0]   IDX_ZERO = {IDXW{1'b0}};

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] word_q,      word_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [IDXW-1:0]  idx_q,       idx_d;
    logic             ser_bit_q,   ser_bit_d;
    logic             ser_last_q,  ser_last_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q,      done_d;
    logic             in_ready_q,  in_ready_d;
    logic             sat_q,       sat_d;

    logic [WIDTH-1:0] gen_word_s;
    logic             gen_sat_s;

    therm_gen #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_therm_gen (
        .count (in_count),
        .mode  (in_mode),
        .word  (gen_word_s),
        .sat   (gen_sat_s)
    );

    // Frame FSM next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        ser_bit_d   = ser_bit_q;
        ser_last_d  = ser_last_q;
        ser_valid_d = ser_valid_q;
        done_d      = 1'b0;
        in_ready_d  = in_ready_q;
        sat_d       = sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d     = SHIFT;
                    word_d      = gen_word_s;
                    shreg_d     = gen_word_s;
                    idx_d       = IDX_ZERO;
                    ser_bit_d   = gen_word_s[0];
                    ser_last_d  = (LAST_IDX == IDX_ZERO);
                    ser_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    sat_d       = sat_q | gen_sat_s;
                end else begin
                    in_ready_d  = 1'b1;
                    ser_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                // Only an accepted beat moves the frame; a stall holds bit, last and index.
                if (ser_valid_q && ser_ready) begin
                    if (ser_last_q) begin
                        state_d     = DONE;
                        ser_valid_d = 1'b0;
                        ser_bit_d   = 1'b0;
                        ser_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d       = idx_q + IDX_ONE;
                        shreg_d     = {1'b0, shreg_q[WIDTH-1:1]};
                        ser_bit_d   = shreg_q[1];
                        ser_last_d  = ((idx_q + IDX_ONE) == LAST_IDX);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                ser_valid_d = 1'b0;
                ser_bit_d   = 1'b0;
                ser_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= {WIDTH{1'b0}};
            shreg_q     <= {WIDTH{1'b0}};
            idx_q       <= IDX_ZERO;
            ser_bit_q   <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            ser_bit_q   <= ser_bit_d;
            ser_last_q  <= ser_last_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign word_out  = word_q;
    assign ser_valid = ser_valid_q;
    assign ser_bit   = ser_bit_q;
    assign ser_last  = ser_last_q;
    assign done      = done_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_ones_pattern_tx.sv
// Scoreboard bench for ones_pattern_tx: a 7-bit and a 5-bit instance, directed
// frames with hand-computed words, monitors that deserialize and count ones.
module tb_ones_pattern_tx;

    typedef struct {
        logic       b;
        logic       last;
        logic [6:0] word;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0, a_ser_ready = 1'b1;
    logic [2:0] a_in_count = 3'd0;
    logic [6:0] a_word_out;
    logic       a_ser_valid, a_ser_bit, a_ser_last, a_done, a_sat;

    logic       b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0, b_ser_ready = 1'b1;
    logic [2:0] b_in_count = 3'd0;
    logic [4:0] b_word_out;
    logic       b_ser_valid, b_ser_bit, b_ser_last, b_done, b_sat;

    beat_t exp_a[$], exp_b[$];
    int    cnt_a[$], cnt_b[$];
    int    n_chk = 0, n_pass = 0;
    int    done_a_n = 0, done_b_n = 0;

    ones_pattern_tx #(.WIDTH(7), .CW(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_count(a_in_count), .in_mode(a_in_mode), .word_out(a_word_out),
        .ser_valid(a_ser_valid), .ser_ready(a_ser_ready), .ser_bit(a_ser_bit),
        .ser_last(a_ser_last), .done(a_done), .sat(a_sat)
    );

    ones_pattern_tx #(.WIDTH(5), .CW(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_count(b_in_count), .in_mode(b_in_mode), .word_out(b_word_out),
        .ser_valid(b_ser_valid), .ser_ready(b_ser_ready), .ser_bit(b_ser_bit),
        .ser_last(b_ser_last), .done(b_done), .sat(b_sat)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor A: compare each presented beat with the queue head, pop on acceptance, loop back the count.
    initial begin
        logic [6:0] rx = 7'd0;
        int         ridx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx = 7'd0;
                ridx = 0;
            end else begin
                if (a_ser_valid) begin
                    if (exp_a.size() == 0) chk("a_unexpected_beat", 32'd1, 32'd0);
                    else begin
                        chk("a_ser_bit", 32'(a_ser_bit), 32'(exp_a[0].b));
                        chk("a_ser_last", 32'(a_ser_last), 32'(exp_a[0].last));
                        chk("a_word_out", 32'(a_word_out), 32'(exp_a[0].word));
                        if (a_ser_ready) begin
                            if (ridx < 7) rx[ridx] = a_ser_bit;
                            ridx++;
                            if (a_ser_last) begin
                                if (cnt_a.size() == 0) chk("a_unexpected_frame", 32'd1, 32'd0);
                                else chk("a_loopback_ones", 32'($countones(rx)), 32'(cnt_a.pop_front()));
                                rx = 7'd0;
                                ridx = 0;
                            end
                            void'(exp_a.pop_front());
                        end
                    end
                end
                if (a_done) done_a_n++;
            end
        end
    end

    // Monitor B: same scoreboard for the 5-bit instance.
    initial begin
        logic [6:0] rx = 7'd0;
        int         ridx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx = 7'd0;
                ridx = 0;
            end else begin
                if (b_ser_valid) begin
                    if (exp_b.size() == 0) chk("b_unexpected_beat", 32'd1, 32'd0);
                    else begin
                        chk("b_ser_bit", 32'(b_ser_bit), 32'(exp_b[0].b));
                        chk("b_ser_last", 32'(b_ser_last), 32'(exp_b[0].last));
                        chk("b_word_out", 32'(b_word_out), 32'(exp_b[0].word));
                        if (b_ser_ready) begin
                            if (ridx < 7) rx[ridx] = b_ser_bit;
                            ridx++;
                            if (b_ser_last) begin
                                if (cnt_b.size() == 0) chk("b_unexpected_frame", 32'd1, 32'd0);
                                else chk("b_loopback_ones", 32'($countones(rx)), 32'(cnt_b.pop_front()));
                                rx = 7'd0;
                                ridx = 0;
                            end
                            void'(exp_b.pop_front());
                        end
                    end
                end
                if (b_done) done_b_n++;
            end
        end
    end

    task automatic set_in(input bit sel_b, input logic v, input logic [2:0] c, input logic m);
        if (sel_b) begin b_in_valid = v; b_in_count = c; b_in_mode = m; end
        else begin a_in_valid = v; a_in_count = c; a_in_mode = m; end
    endtask

    // One full frame: push expectations, present the count, run the link, check done timing and return to idle.
    task automatic send(input bit sel_b, input logic [2:0] cnt, input logic mode,
                        input logic [6:0] word, input int ones, input bit toggle, input bit poke);
        int w   = sel_b ? 5 : 7;
        bit got = 1'b0;
        int dc  = 0;
        for (int i = 0; i < w; i++) begin
            beat_t e;
            e.b = word[i];
            e.last = (i == w - 1);
            e.word = word;
            if (sel_b) exp_b.push_back(e); else exp_a.push_back(e);
        end
        if (sel_b) cnt_b.push_back(ones); else cnt_a.push_back(ones);
        set_in(sel_b, 1'b1, cnt, mode);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(sel_b ? b_in_ready : a_in_ready), 32'd1);
        @(posedge clk); #1;
        set_in(sel_b, 1'b0, 3'd0, 1'b0);
        for (int c = 1; c <= 60 && !got; c++) begin
            if (sel_b) b_ser_ready = toggle ? ((c - 1) % 3 == 0) : 1'b1;
            else       a_ser_ready = toggle ? ((c - 1) % 3 == 0) : 1'b1;
            if (poke) set_in(sel_b, (c == 2 || c == 3), 3'd1, 1'b0);
            @(negedge clk);
            if (sel_b ? b_done : a_done) begin got = 1'b1; dc = c; end
            @(posedge clk); #1;
        end
        set_in(sel_b, 1'b0, 3'd0, 1'b0);
        if (sel_b) b_ser_ready = 1'b1; else a_ser_ready = 1'b1;
        chk("done_seen", 32'(got), 32'd1);
        if (!toggle) chk("done_cycle", 32'(dc), 32'(w + 1));
        @(negedge clk);
        chk("in_ready_after_done", 32'(sel_b ? b_in_ready : a_in_ready), 32'd1);
        chk("done_one_cycle", 32'(sel_b ? b_done : a_done), 32'd0);
        chk("idle_ser_valid", 32'(sel_b ? b_ser_valid : a_ser_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_ser_valid", 32'(a_ser_valid), 32'd0);
        chk("rst_a_ser_bit", 32'(a_ser_bit), 32'd0);
        chk("rst_a_ser_last", 32'(a_ser_last), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_a_sat", 32'(a_sat), 32'd0);
        chk("rst_a_word_out", 32'(a_word_out), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        chk("rst_b_word_out", 32'(b_word_out), 32'd0);
        @(posedge clk); #1;

        send(1'b0, 3'd3, 1'b0, 7'b0000111, 3, 1'b0, 1'b0);
        send(1'b0, 3'd3, 1'b1, 7'b1110000, 3, 1'b0, 1'b1);
        send(1'b0, 3'd0, 1'b0, 7'b0000000, 0, 1'b0, 1'b0);
        send(1'b0, 3'd0, 1'b1, 7'b0000000, 0, 1'b0, 1'b0);
        send(1'b0, 3'd7, 1'b0, 7'b1111111, 7, 1'b0, 1'b0);
        send(1'b0, 3'd7, 1'b1, 7'b1111111, 7, 1'b0, 1'b0);
        send(1'b0, 3'd5, 1'b0, 7'b0011111, 5, 1'b1, 1'b0);

        // Abort a count-6 frame with reset while beat 3 is on the wire.
        for (int i = 0; i < 3; i++) begin
            beat_t e;
            e.b = 1'b1;
            e.last = 1'b0;
            e.word = 7'b0111111;
            exp_a.push_back(e);
        end
        set_in(1'b0, 1'b1, 3'd6, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ser_valid", 32'(a_ser_valid), 32'd0);
        chk("abort_in_ready", 32'(a_in_ready), 32'd1);
        chk("abort_word_out", 32'(a_word_out), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_beats_consumed", 32'(exp_a.size()), 32'd0);
        @(posedge clk); #1;
        send(1'b0, 3'd2, 1'b0, 7'b0000011, 2, 1'b0, 1'b0);

        chk("a_done_count", 32'(done_a_n), 32'd8);
        chk("a_sat_never", 32'(a_sat), 32'd0);

        send(1'b1, 3'd6, 1'b0, 7'b0011111, 5, 1'b0, 1'b1);
        chk("b_sat_set", 32'(b_sat), 32'd1);
        send(1'b1, 3'd2, 1'b1, 7'b0011000, 2, 1'b0, 1'b0);
        chk("b_sat_sticky", 32'(b_sat), 32'd1);
        send(1'b1, 3'd4, 1'b0, 7'b0001111, 4, 1'b0, 1'b0);
        send(1'b1, 3'd7, 1'b1, 7'b0011111, 5, 1'b0, 1'b0);
        chk("b_word_held_after_done", 32'(b_word_out), 32'h1f);
        chk("b_done_count", 32'(done_b_n), 32'd4);
        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("b_sat_cleared_by_rst", 32'(b_sat), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
